// File: rtl/aes_pkg.sv
// aes_pkg: shared AES types, round-count constants, S-box table and GF(2^8) helpers
package aes_pkg;
    localparam int NR_128 = 10;
    localparam int NR_192 = 12;
    localparam int NR_256 = 14;

    typedef logic [127:0] aes_state_t;
    typedef enum logic [1:0] {IDLE, ROUND, DONE} fsm_e;

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[b];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = '0;
        x = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction
endpackage

// File: rtl/aes_round_engine_round.sv
// aes_round: one combinational AES round (SubBytes, ShiftRows, optional MixColumns, AddRoundKey)
module aes_round
    import aes_pkg::*;
(
    input  aes_state_t state_i,
    input  aes_state_t rk_i,
    input  logic       final_i,
    output aes_state_t state_o
);
    logic [7:0] sb [16];
    logic [7:0] sr [16];
    logic [7:0] mc [16];

    genvar i, c;
    // byte i sits at row i%4, column i/4; row r rotates left by r columns
    for (i = 0; i < 16; i++) begin : g_byte
        assign sb[i] = sbox(state_i[127-8*i -: 8]);
        assign sr[i] = sb[i%4 + 4*((i/4 + i%4) % 4)];
        assign state_o[127-8*i -: 8] = (final_i ? sr[i] : mc[i]) ^ rk_i[127-8*i -: 8];
    end

    for (c = 0; c < 4; c++) begin : g_col
        assign mc[4*c]   = gmul(sr[4*c], 8'h02) ^ gmul(sr[4*c+1], 8'h03) ^ sr[4*c+2] ^ sr[4*c+3];
        assign mc[4*c+1] = sr[4*c] ^ gmul(sr[4*c+1], 8'h02) ^ gmul(sr[4*c+2], 8'h03) ^ sr[4*c+3];
        assign mc[4*c+2] = sr[4*c] ^ sr[4*c+1] ^ gmul(sr[4*c+2], 8'h02) ^ gmul(sr[4*c+3], 8'h03);
        assign mc[4*c+3] = gmul(sr[4*c], 8'h03) ^ sr[4*c+1] ^ sr[4*c+2] ^ gmul(sr[4*c+3], 8'h02);
    end
endmodule

// File: rtl/aes_round_engine.sv
// aes_round_engine: iterative AES encryptor, one round per cycle, round keys fetched from an external store
module aes_round_engine
    import aes_pkg::*;
#(
    parameter int NR  = NR_128,
    parameter int KIW = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           flush,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [127:0]   IN,
    output logic [KIW-1:0] key_idx,
    input  logic [127:0]   keys,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [127:0]   OUT,
    output logic           busy
);
    localparam logic [KIW-1:0] LAST = KIW'(NR);

    fsm_e           st_q, st_d;
    logic [KIW-1:0] rnd_q, rnd_d;
    aes_state_t     s_q, s_d, out_q, out_d, rnd_out;
    logic           last;

    assign last      = rnd_q == LAST;
    assign out_valid = st_q == DONE;
    assign busy      = st_q != IDLE;
    assign OUT       = out_q;

    aes_round u_round (
        .state_i (s_q),
        .rk_i    (keys),
        .final_i (last),
        .state_o (rnd_out)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q  <= IDLE;
            rnd_q <= '0;
            s_q   <= '0;
            out_q <= '0;
        end else begin
            st_q  <= st_d;
            rnd_q <= rnd_d;
            s_q   <= s_d;
            out_q <= out_d;
        end
    end

    always_comb begin
        st_d     = st_q;
        rnd_d    = rnd_q;
        s_d      = s_q;
        out_d    = out_q;
        in_ready = (st_q == IDLE) || (st_q == DONE && out_ready);
        key_idx  = (st_q == ROUND) ? rnd_q : '0;
        if (flush) begin
            st_d = IDLE;
        end else begin
            case (st_q)
                IDLE, DONE: begin
                    // key_idx is 0 here, so keys carries the whitening key
                    if (in_valid && in_ready) begin
                        s_d   = IN ^ keys;
                        rnd_d = KIW'(1);
                        st_d  = ROUND;
                    end else if (st_q == DONE && out_ready) begin
                        st_d = IDLE;
                    end
                end
                ROUND: begin
                    s_d = rnd_out;
                    if (last) begin
                        out_d = rnd_out;
                        st_d  = DONE;
                    end else begin
                        rnd_d = rnd_q + KIW'(1);
                    end
                end
                default: st_d = IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_aes_round_engine.sv
// tb_aes_round_engine: directed checks of the AES round engine against FIPS-197 vectors and a reference model
module tb_aes_round_engine;
    localparam logic [127:0] PT     = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT128  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] CT256  = 128'h8ea2b7ca516745bfeafc49904b496089;

    logic         clk = 0, rst_n = 0, flush = 0;
    logic [127:0] in_blk = '0;
    logic         iv10 = 0, or10 = 0, ir10, ov10, bz10;
    logic         iv14 = 0, or14 = 0, ir14, ov14, bz14;
    logic [3:0]   ki10, ki14;
    logic [127:0] k10, k14, o10, o14;
    logic [127:0] rk10 [15];
    logic [127:0] rk14 [15];
    logic [7:0]   ms [256];
    int           n_cmp = 0, n_err = 0;

    always #5 clk = ~clk;

    assign k10 = (ki10 <= 4'd14) ? rk10[ki10] : '0;
    assign k14 = (ki14 <= 4'd14) ? rk14[ki14] : '0;

    aes_round_engine #(.NR(10), .KIW(4)) u10 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(iv10), .in_ready(ir10), .IN(in_blk),
        .key_idx(ki10), .keys(k10), .out_valid(ov10), .out_ready(or10), .OUT(o10), .busy(bz10)
    );

    aes_round_engine #(.NR(14), .KIW(4)) u14 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(iv14), .in_ready(ir14), .IN(in_blk),
        .key_idx(ki14), .keys(k14), .out_valid(ov14), .out_ready(or14), .OUT(o14), .busy(bz14)
    );

    function automatic logic [7:0] m_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = '0;
        x = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
        logic [15:0] d;
        d = {b, b};
        return d[15-n -: 8];
    endfunction

    // S-box derived from the GF(2^8) inverse and affine map, independent of any table
    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = '0;
            for (int y = 1; y < 256; y++) if (m_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            ms[x] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] subw(input logic [31:0] t);
        return {ms[t[31:24]], ms[t[23:16]], ms[t[15:8]], ms[t[7:0]]};
    endfunction

    task automatic expand(input logic [255:0] key, input int nk, input int nr, input bit is14);
        logic [31:0] w [60];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
        for (int i = nk; i < 4*(nr+1); i++) begin
            t = w[i-1];
            if (i % nk == 0) begin
                t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = m_mul(rc, 8'h02);
            end else if (nk > 6 && i % nk == 4) begin
                t = subw(t);
            end
            w[i] = w[i-nk] ^ t;
        end
        for (int r = 0; r <= nr; r++) begin
            if (is14) rk14[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
            else      rk10[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
        end
    endtask

    function automatic logic [127:0] m_enc(input logic [127:0] pt, input int nr, input bit is14);
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [7:0]   cf [4];
        logic [127:0] k, res;
        cf = '{8'h02, 8'h03, 8'h01, 8'h01};
        k = is14 ? rk14[0] : rk10[0];
        for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ k[127-8*i -: 8];
        for (int r = 1; r <= nr; r++) begin
            for (int i = 0; i < 16; i++) t[i] = ms[s[(i + 4*(i%4)) % 16]];
            for (int c = 0; c < 4; c++)
                for (int row = 0; row < 4; row++) begin
                    s[4*c+row] = (r == nr) ? t[4*c+row] : 8'h00;
                    if (r != nr)
                        for (int j = 0; j < 4; j++) s[4*c+row] = s[4*c+row] ^ m_mul(cf[(j-row+4)%4], t[4*c+j]);
                end
            k = is14 ? rk14[r] : rk10[r];
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ k[127-8*i -: 8];
        end
        for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
        return res;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #3;
        n_cmp += 5;
        if (ov10 !== 1'b0) begin n_err++; $display("FAIL rst_out_valid: got %b want 0", ov10); end
        if (o10 !== '0) begin n_err++; $display("FAIL rst_OUT: got %h want 0", o10); end
        if (bz10 !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b want 0", bz10); end
        if (ir10 !== 1'b1) begin n_err++; $display("FAIL rst_in_ready: got %b want 1", ir10); end
        if (ki10 !== 4'd0) begin n_err++; $display("FAIL rst_key_idx: got %0d want 0", ki10); end
        @(negedge clk);
        rst_n = 1;
        tick();
        n_cmp += 3;
        if (ir10 !== 1'b1) begin n_err++; $display("FAIL post_rst_in_ready: got %b want 1", ir10); end
        if (ki10 !== 4'd0) begin n_err++; $display("FAIL post_rst_key_idx: got %0d want 0", ki10); end
        if (ov14 !== 1'b0) begin n_err++; $display("FAIL post_rst_out_valid14: got %b want 0", ov14); end
    endtask

    task automatic test_fips128();
        int n;
        in_blk = PT;
        iv10 = 1;
        #1;
        n_cmp++;
        if (ir10 !== 1'b1) begin n_err++; $display("FAIL idle_in_ready: got %b want 1", ir10); end
        tick();
        n = 0;
        while (!ov10 && n < 40) begin
            n_cmp += 2;
            if (ki10 !== 4'(n+1)) begin n_err++; $display("FAIL key_idx10 step %0d: got %0d want %0d", n, ki10, n+1); end
            if (ir10 !== 1'b0) begin n_err++; $display("FAIL round_in_ready step %0d: got %b want 0", n, ir10); end
            iv10 = ~iv10;
            in_blk = {$urandom, $urandom, $urandom, $urandom};
            tick();
            n++;
        end
        iv10 = 0;
        n_cmp += 3;
        if (n !== 10) begin n_err++; $display("FAIL latency10: got %0d want 10", n); end
        if (o10 !== CT128) begin n_err++; $display("FAIL fips128_OUT: got %h want %h", o10, CT128); end
        if (ki10 !== 4'd0) begin n_err++; $display("FAIL done_key_idx: got %0d want 0", ki10); end
    endtask

    task automatic test_back_to_back();
        int n;
        logic [127:0] pt2, exp2;
        for (int c = 0; c < 5; c++) begin
            tick();
            n_cmp += 3;
            if (ov10 !== 1'b1) begin n_err++; $display("FAIL stall_out_valid cyc %0d: got %b want 1", c, ov10); end
            if (o10 !== CT128) begin n_err++; $display("FAIL stall_OUT cyc %0d: got %h want %h", c, o10, CT128); end
            if (ir10 !== 1'b0) begin n_err++; $display("FAIL stall_in_ready cyc %0d: got %b want 0", c, ir10); end
        end
        pt2 = {$urandom, $urandom, $urandom, $urandom};
        exp2 = m_enc(pt2, 10, 1'b0);
        in_blk = pt2;
        iv10 = 1;
        or10 = 1;
        #1;
        n_cmp++;
        if (ir10 !== 1'b1) begin n_err++; $display("FAIL b2b_in_ready: got %b want 1", ir10); end
        tick();
        iv10 = 0;
        or10 = 0;
        in_blk = ~pt2;
        n_cmp += 3;
        if (ov10 !== 1'b0) begin n_err++; $display("FAIL b2b_out_valid: got %b want 0", ov10); end
        if (ki10 !== 4'd1) begin n_err++; $display("FAIL b2b_key_idx: got %0d want 1", ki10); end
        if (bz10 !== 1'b1) begin n_err++; $display("FAIL b2b_busy: got %b want 1", bz10); end
        n = 0;
        while (!ov10 && n < 40) begin tick(); n++; end
        n_cmp += 2;
        if (n !== 10) begin n_err++; $display("FAIL b2b_latency: got %0d want 10", n); end
        if (o10 !== exp2) begin n_err++; $display("FAIL b2b_OUT: got %h want %h", o10, exp2); end
        or10 = 1;
        tick();
        or10 = 0;
        n_cmp += 3;
        if (bz10 !== 1'b0) begin n_err++; $display("FAIL drain_busy: got %b want 0", bz10); end
        if (ov10 !== 1'b0) begin n_err++; $display("FAIL drain_out_valid: got %b want 0", ov10); end
        if (o10 !== exp2) begin n_err++; $display("FAIL drain_OUT_hold: got %h want %h", o10, exp2); end
    endtask

    task automatic test_flush();
        int n;
        logic [127:0] held;
        held = o10;
        in_blk = {$urandom, $urandom, $urandom, $urandom};
        iv10 = 1;
        tick();
        iv10 = 0;
        tick();
        tick();
        tick();
        n_cmp++;
        if (ki10 !== 4'd4) begin n_err++; $display("FAIL flush_at_round: got %0d want 4", ki10); end
        flush = 1;
        iv10 = 1;
        or10 = 1;
        tick();
        flush = 0;
        iv10 = 0;
        or10 = 0;
        n_cmp += 4;
        if (bz10 !== 1'b0) begin n_err++; $display("FAIL flush_busy: got %b want 0", bz10); end
        if (ov10 !== 1'b0) begin n_err++; $display("FAIL flush_out_valid: got %b want 0", ov10); end
        if (ir10 !== 1'b1) begin n_err++; $display("FAIL flush_in_ready: got %b want 1", ir10); end
        if (o10 !== held) begin n_err++; $display("FAIL flush_OUT_hold: got %h want %h", o10, held); end
        for (int c = 0; c < 12; c++) begin
            tick();
            n_cmp++;
            if (ov10 !== 1'b0) begin n_err++; $display("FAIL flush_quiet cyc %0d: got %b want 0", c, ov10); end
        end
        in_blk = PT;
        iv10 = 1;
        tick();
        iv10 = 0;
        n = 0;
        while (!ov10 && n < 40) begin tick(); n++; end
        n_cmp += 2;
        if (n !== 10) begin n_err++; $display("FAIL post_flush_latency: got %0d want 10", n); end
        if (o10 !== CT128) begin n_err++; $display("FAIL post_flush_OUT: got %h want %h", o10, CT128); end
        // flush must win over a simultaneous drain-and-accept in DONE
        flush = 1;
        or10 = 1;
        iv10 = 1;
        tick();
        flush = 0;
        or10 = 0;
        iv10 = 0;
        n_cmp += 3;
        if (bz10 !== 1'b0) begin n_err++; $display("FAIL flush_prio_busy: got %b want 0", bz10); end
        if (ov10 !== 1'b0) begin n_err++; $display("FAIL flush_prio_out_valid: got %b want 0", ov10); end
        if (ki10 !== 4'd0) begin n_err++; $display("FAIL flush_prio_key_idx: got %0d want 0", ki10); end
    endtask

    task automatic test_async_reset();
        in_blk = {$urandom, $urandom, $urandom, $urandom};
        iv10 = 1;
        tick();
        iv10 = 0;
        tick();
        tick();
        #2;
        rst_n = 0;
        #1;
        n_cmp += 5;
        if (ov10 !== 1'b0) begin n_err++; $display("FAIL arst_out_valid: got %b want 0", ov10); end
        if (o10 !== '0) begin n_err++; $display("FAIL arst_OUT: got %h want 0", o10); end
        if (bz10 !== 1'b0) begin n_err++; $display("FAIL arst_busy: got %b want 0", bz10); end
        if (ki10 !== 4'd0) begin n_err++; $display("FAIL arst_key_idx: got %0d want 0", ki10); end
        if (ir10 !== 1'b1) begin n_err++; $display("FAIL arst_in_ready: got %b want 1", ir10); end
        @(negedge clk);
        rst_n = 1;
        tick();
        n_cmp += 2;
        if (ir10 !== 1'b1) begin n_err++; $display("FAIL arst_rel_in_ready: got %b want 1", ir10); end
        if (ov10 !== 1'b0) begin n_err++; $display("FAIL arst_rel_out_valid: got %b want 0", ov10); end
    endtask

    task automatic test_nr14();
        int n;
        in_blk = PT;
        iv14 = 1;
        #1;
        n_cmp += 2;
        if (ki14 !== 4'd0) begin n_err++; $display("FAIL nr14_idle_key_idx: got %0d want 0", ki14); end
        if (ir14 !== 1'b1) begin n_err++; $display("FAIL nr14_in_ready: got %b want 1", ir14); end
        tick();
        iv14 = 0;
        n = 0;
        while (!ov14 && n < 40) begin
            n_cmp++;
            if (ki14 !== 4'(n+1)) begin n_err++; $display("FAIL key_idx14 step %0d: got %0d want %0d", n, ki14, n+1); end
            tick();
            n++;
        end
        n_cmp += 3;
        if (n !== 14) begin n_err++; $display("FAIL latency14: got %0d want 14", n); end
        if (o14 !== CT256) begin n_err++; $display("FAIL fips256_OUT: got %h want %h", o14, CT256); end
        if (ki14 !== 4'd0) begin n_err++; $display("FAIL nr14_done_key_idx: got %0d want 0", ki14); end
        or14 = 1;
        tick();
        or14 = 0;
        n_cmp++;
        if (bz14 !== 1'b0) begin n_err++; $display("FAIL nr14_drain_busy: got %b want 0", bz14); end
    endtask

    initial begin
        build_sbox();
        expand({128'h000102030405060708090a0b0c0d0e0f, 128'h0}, 4, 10, 1'b0);
        expand(256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 8, 14, 1'b1);
        test_reset();
        test_fips128();
        test_back_to_back();
        test_flush();
        test_async_reset();
        test_nr14();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
